// File: rtl/an_grid_pkg.sv
// ---------------------------------------------------------------------------
// an_grid_pkg
// Shared constants, helper functions and the controller state type for the
// AN-code grid corrector. The *_DEF values are the default build of the
// block. The helper functions let each module derive its own constants from
// its actual parameters.
// ---------------------------------------------------------------------------
package an_grid_pkg;

  localparam int A_DEF    = 13;
  localparam int CW_DEF   = 6;
  localparam int MW_DEF   = 3;
  localparam int RW_DEF   = 4;
  localparam int ROWS_DEF = 4;
  localparam int COLS_DEF = 4;

  // Barrett multiplier floor(2^(2*cw) / a).
  function automatic int barrett_m(input int a, input int cw);
    return (1 << (2 * cw)) / a;
  endfunction

  // Residue of +2^k modulo a.
  function automatic int pow2_mod(input int a, input int k);
    return (1 << k) % a;
  endfunction

  // Quotient floor(2^k / a). A single-bit error moves the quotient by this
  // amount, or by this amount plus one.
  function automatic int pow2_div(input int a, input int k);
    return (1 << k) / a;
  endfunction

  localparam int K     = 2 * CW_DEF;
  localparam int M     = barrett_m(A_DEF, CW_DEF);
  localparam int N     = ROWS_DEF * COLS_DEF;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DETECT,
    ST_SCAN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/an_barrett_cell.sv
// ---------------------------------------------------------------------------
// an_barrett_cell
// Purely combinational AN-code decode of one codeword.
// It uses Barrett reduction to form quotient and residue without a divider.
// The Barrett estimate is never above the true quotient and is at most one
// below it, so a single conditional subtract gives exact q and r.
//   cw_i  : codeword
//   msg_o : quotient truncated to the message width
//   r_o   : residue cw mod A
//   err_o : residue is nonzero
// ---------------------------------------------------------------------------
module an_barrett_cell
  import an_grid_pkg::*;
#(
  parameter int A  = A_DEF,
  parameter int CW = CW_DEF,
  parameter int MW = MW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic [CW-1:0] cw_i,
  output logic [MW-1:0] msg_o,
  output logic [RW-1:0] r_o,
  output logic          err_o
);

  localparam int KB  = 2 * CW;
  localparam int MB  = barrett_m(A, CW);
  localparam int PW  = CW + $clog2(MB + 1);
  localparam int RXW = CW + 2;

  logic [PW-1:0]  prod;
  logic [CW-1:0]  q_est;
  logic [CW-1:0]  q_fix;
  logic [RXW-1:0] r_raw;
  logic [RXW-1:0] r_fix;

  // Estimate, then apply one correction step when the residue is still >= A.
  always_comb begin
    prod  = PW'(cw_i) * PW'(MB);
    q_est = CW'(prod >> KB);
    r_raw = RXW'(cw_i) - RXW'(q_est) * RXW'(A);
    if (r_raw >= RXW'(A)) begin
      r_fix = r_raw - RXW'(A);
      q_fix = q_est + CW'(1);
    end else begin
      r_fix = r_raw;
      q_fix = q_est;
    end
    msg_o = MW'(q_fix);
    r_o   = RW'(r_fix);
    err_o = (r_fix != '0);
  end

endmodule

// File: rtl/an_grid_corrector.sv
// ---------------------------------------------------------------------------
// an_grid_corrector
// Decodes a ROWS x COLS grid of AN-coded words. A cell is corrected only when
// its own residue is nonzero and both its row and its column show an error.
// The fix assumes a single-bit error of +/-2^k in that cell. One shared
// corrector walks the cells one per cycle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : grid handshake; in_cw cell i at [i*CW +: CW]
//   out_valid/out_ready : result handshake; held stable until taken
//   out_msg             : decoded messages, cell i at [i*MW +: MW]
//   out_err_map         : cells with a nonzero residue
//   out_err_count       : number of successfully corrected cells
//   out_uncorr          : some candidate cell could not be corrected
// ---------------------------------------------------------------------------
module an_grid_corrector
  import an_grid_pkg::*;
#(
  parameter int A    = A_DEF,
  parameter int CW   = CW_DEF,
  parameter int MW   = MW_DEF,
  parameter int RW   = RW_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ROWS*COLS*CW-1:0]           in_cw,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ROWS*COLS*MW-1:0]           out_msg,
  output logic [ROWS*COLS-1:0]              out_err_map,
  output logic [$clog2(ROWS*COLS+1)-1:0]    out_err_count,
  output logic                              out_uncorr
);

  localparam int NC   = ROWS * COLS;
  localparam int CNTW = $clog2(NC + 1);
  localparam int IDXW = (NC > 1) ? $clog2(NC) : 1;
  localparam int PTRW = CNTW;

  state_e state_q, state_d;

  logic [CW-1:0]   cw_q     [NC];
  logic [MW-1:0]   cell_msg [NC];
  logic [RW-1:0]   cell_r   [NC];
  logic [NC-1:0]   cell_err;
  logic [ROWS-1:0] er_d;
  logic [COLS-1:0] ec_d;

  logic [MW-1:0]   qmsg_q [NC];
  logic [RW-1:0]   r_q    [NC];
  logic [NC-1:0]   err_q;
  logic [ROWS-1:0] er_q;
  logic [COLS-1:0] ec_q;
  logic [NC-1:0]   cand;

  logic [MW-1:0]   omsg_q [NC];
  logic [CNTW-1:0] cnt_q;
  logic            uncorr_q;

  logic [PTRW-1:0] ptr_q;
  logic [IDXW-1:0] ptr_idx;

  logic            sel_valid_q;
  logic [IDXW-1:0] sel_idx_q;
  logic [MW-1:0]   sel_msg_q;
  logic [RW-1:0]   sel_r_q;
  logic [CW-1:0]   sel_cw_q;
  logic            sel_cand_q;

  logic            fix_found;
  logic            fix_ok;
  logic [MW-1:0]   fix_msg;

  genvar g;
  generate
    for (g = 0; g < NC; g++) begin : g_cell
      an_barrett_cell #(
        .A  (A),
        .CW (CW),
        .MW (MW),
        .RW (RW)
      ) u_cell (
        .cw_i  (cw_q[g]),
        .msg_o (cell_msg[g]),
        .r_o   (cell_r[g]),
        .err_o (cell_err[g])
      );
    end
  endgenerate

  // Row and column error flags from the live cell decodes.
  always_comb begin
    er_d = '0;
    ec_d = '0;
    for (int i = 0; i < NC; i++) begin
      er_d[i / COLS] = er_d[i / COLS] | cell_err[i];
      ec_d[i % COLS] = ec_d[i % COLS] | cell_err[i];
    end
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < NC; i++) begin
      cand[i] = err_q[i] & er_q[i / COLS] & ec_q[i % COLS];
    end
  end

  assign ptr_idx = ptr_q[IDXW-1:0];

  // Shared corrector. For a residue r, the +2^k hypothesis gives q - floor(2^k/A).
  // The -2^k hypothesis gives q + floor(2^k/A) + 1. These are only valid when
  // cw -/+ 2^k stays inside the codeword range.
  always_comb begin
    fix_found = 1'b0;
    fix_ok    = 1'b0;
    fix_msg   = sel_msg_q;
    for (int k = 0; k < CW; k++) begin
      if (!fix_found && int'(sel_r_q) == pow2_mod(A, k)) begin
        fix_found = 1'b1;
        if (int'(sel_cw_q) >= (1 << k)) begin
          fix_ok  = 1'b1;
          fix_msg = sel_msg_q - MW'(pow2_div(A, k));
        end
      end
    end
    for (int k = 0; k < CW; k++) begin
      if (!fix_found && int'(sel_r_q) == (A - pow2_mod(A, k)) % A) begin
        fix_found = 1'b1;
        if (int'(sel_cw_q) + (1 << k) < (1 << CW)) begin
          fix_ok  = 1'b1;
          fix_msg = sel_msg_q + MW'(pow2_div(A, k) + 1);
        end
      end
    end
  end

  // Controller next state. SCAN ends once the last cell has been written.
  // Selection is registered one cycle ahead of the write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid) state_d = ST_DETECT;
      ST_DETECT: state_d = ST_SCAN;
      ST_SCAN:   if (sel_valid_q && sel_idx_q == IDXW'(NC - 1)) state_d = ST_DONE;
      ST_DONE:   if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: capture, detect, then scan one cell per cycle through a
  // one-stage select/write pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        cw_q[i]   <= '0;
        qmsg_q[i] <= '0;
        r_q[i]    <= '0;
        omsg_q[i] <= '0;
      end
      err_q       <= '0;
      er_q        <= '0;
      ec_q        <= '0;
      cnt_q       <= '0;
      uncorr_q    <= 1'b0;
      ptr_q       <= '0;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= '0;
      sel_msg_q   <= '0;
      sel_r_q     <= '0;
      sel_cw_q    <= '0;
      sel_cand_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NC; i++) cw_q[i] <= in_cw[i*CW +: CW];
          end
        end
        ST_DETECT: begin
          for (int i = 0; i < NC; i++) begin
            qmsg_q[i] <= cell_msg[i];
            r_q[i]    <= cell_r[i];
          end
          err_q       <= cell_err;
          er_q        <= er_d;
          ec_q        <= ec_d;
          cnt_q       <= '0;
          uncorr_q    <= 1'b0;
          ptr_q       <= '0;
          sel_valid_q <= 1'b0;
        end
        ST_SCAN: begin
          if (ptr_q < PTRW'(NC)) begin
            sel_valid_q <= 1'b1;
            sel_idx_q   <= ptr_idx;
            sel_msg_q   <= qmsg_q[ptr_idx];
            sel_r_q     <= r_q[ptr_idx];
            sel_cw_q    <= cw_q[ptr_idx];
            sel_cand_q  <= cand[ptr_idx];
            ptr_q       <= ptr_q + PTRW'(1);
          end else begin
            sel_valid_q <= 1'b0;
          end
          if (sel_valid_q) begin
            if (sel_cand_q && fix_ok) begin
              omsg_q[sel_idx_q] <= fix_msg;
              cnt_q             <= cnt_q + CNTW'(1);
            end else begin
              omsg_q[sel_idx_q] <= sel_msg_q;
              if (sel_cand_q) uncorr_q <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    out_msg = '0;
    for (int i = 0; i < NC; i++) out_msg[i*MW +: MW] = omsg_q[i];
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = (state_q == ST_DONE);
  assign out_err_map   = err_q;
  assign out_err_count = cnt_q;
  assign out_uncorr    = uncorr_q;

endmodule

// File: tb/tb_an_grid_corrector.sv
// ---------------------------------------------------------------------------
// tb_an_grid_corrector
// Directed and randomised grids for the AN grid corrector. A behavioural model
// uses real division and an exhaustive error search. It predicts each result
// into a scoreboard queue, which is popped when the DUT raises out_valid.
// ---------------------------------------------------------------------------
module tb_an_grid_corrector;

  localparam int A    = 13;
  localparam int CW   = 6;
  localparam int MW   = 3;
  localparam int RW   = 4;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int NC   = ROWS * COLS;
  localparam int CNTW = $clog2(NC + 1);

  typedef struct {
    logic [NC*MW-1:0] msg;
    logic [NC-1:0]    map;
    logic [CNTW-1:0]  cnt;
    logic             uncorr;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [NC*CW-1:0]  in_cw;
  logic              out_valid;
  logic              out_ready;
  logic [NC*MW-1:0]  out_msg;
  logic [NC-1:0]     out_err_map;
  logic [CNTW-1:0]   out_err_count;
  logic              out_uncorr;

  exp_t sbQueue[$];
  exp_t cur;
  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;
  logic [NC*CW-1:0] grid;

  an_grid_corrector #(
    .A(A), .CW(CW), .MW(MW), .RW(RW), .ROWS(ROWS), .COLS(COLS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_cw         (in_cw),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_msg       (out_msg),
    .out_err_map   (out_err_map),
    .out_err_count (out_err_count),
    .out_uncorr    (out_uncorr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stop a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference decode: exact division, then the first e = +/-2^k whose removal
  // leaves a multiple of A.
  function automatic exp_t model(input logic [NC*CW-1:0] g);
    exp_t x;
    int   cwv[NC];
    bit   er[ROWS];
    bit   ec[COLS];
    int   m, e;
    bit   found;
    x.msg = '0; x.map = '0; x.cnt = '0; x.uncorr = 1'b0;
    for (int j = 0; j < ROWS; j++) er[j] = 1'b0;
    for (int j = 0; j < COLS; j++) ec[j] = 1'b0;
    for (int i = 0; i < NC; i++) begin
      cwv[i] = int'(g[i*CW +: CW]);
      if (cwv[i] % A != 0) begin
        x.map[i] = 1'b1;
        er[i / COLS] = 1'b1;
        ec[i % COLS] = 1'b1;
      end
    end
    for (int i = 0; i < NC; i++) begin
      m = cwv[i] / A;
      if (x.map[i] && er[i / COLS] && ec[i % COLS]) begin
        found = 1'b0;
        for (int k = 0; k < CW; k++) begin
          for (int s = 0; s < 2; s++) begin
            e = (s == 0) ? (1 << k) : -(1 << k);
            if (!found && (((cwv[i] - e) % A) + A) % A == 0) begin
              found = 1'b1;
              if (cwv[i] - e >= 0 && cwv[i] - e < (1 << CW)) begin
                m = (cwv[i] - e) / A;
                x.cnt = x.cnt + 1'b1;
              end else begin
                x.uncorr = 1'b1;
              end
            end
          end
        end
        if (!found) x.uncorr = 1'b1;
      end
      x.msg[i*MW +: MW] = MW'(m);
    end
    return x;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Offer one grid; when pushIt is set the model prediction joins the scoreboard.
  task automatic applyStimulus(input logic [NC*CW-1:0] g, input bit pushIt);
    int waits = 0;
    while (!in_ready && waits < 40) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!in_ready) checkOutput("in_ready_wait", {63'd0, in_ready}, 64'd1);
    in_cw    = g;
    in_valid = 1'b1;
    if (pushIt) sbQueue.push_back(model(g));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count cycles after acceptance until out_valid, then compare against the queue.
  task automatic awaitResult(input string tag, output exp_t res);
    int  lat  = 0;
    bit  seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(NC + 2));
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_queue"}, 64'd0, 64'd1);
      res = '{msg: '0, map: '0, cnt: '0, uncorr: 1'b0};
    end else begin
      res = sbQueue.pop_front();
    end
    checkOutput({tag, "_msg"},    64'(out_msg),       64'(res.msg));
    checkOutput({tag, "_map"},    64'(out_err_map),   64'(res.map));
    checkOutput({tag, "_count"},  64'(out_err_count), 64'(res.cnt));
    checkOutput({tag, "_uncorr"}, {63'd0, out_uncorr}, {63'd0, res.uncorr});
    checkOutput({tag, "_busy"},   {63'd0, in_ready},   64'd0);
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_idle_ready"}, {63'd0, in_ready},  64'd1);
    checkOutput({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
  endtask

  function automatic logic [NC*CW-1:0] fillGrid(input int v);
    logic [NC*CW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*CW +: CW] = CW'(v);
    return r;
  endfunction

  function automatic logic [NC*CW-1:0] randomGrid();
    logic [NC*CW-1:0] r;
    int base, v, e;
    for (int i = 0; i < NC; i++) begin
      base = A * int'($urandom_range(0, 4));
      v = base;
      if ($urandom_range(0, 3) == 0) begin
        e = 1 << $urandom_range(0, CW - 1);
        if ($urandom_range(0, 1) == 1) e = -e;
        if (base + e >= 0 && base + e < (1 << CW)) v = base + e;
      end
      r[i*CW +: CW] = CW'(v);
    end
    return r;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_cw     = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready",  {63'd0, in_ready},  64'd1);
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_msg",       64'(out_msg),       64'd0);
    checkOutput("reset_map",       64'(out_err_map),   64'd0);
    checkOutput("reset_count",     64'(out_err_count), 64'd0);
    checkOutput("reset_uncorr",    {63'd0, out_uncorr}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean grid: every cell 39 = 3*13.
    applyStimulus(fillGrid(39), 1'b1);
    awaitResult("clean", cur);
    checkOutput("clean_all3", 64'(out_msg), 64'({NC{3'd3}}));
    checkOutput("clean_map0", 64'(out_err_map), 64'd0);
    releaseResult("clean");

    // Single +4 error at cell 5. Also hold out_ready low for 10 cycles.
    grid = fillGrid(39);
    grid[5*CW +: CW] = 6'd43;
    applyStimulus(grid, 1'b1);
    awaitResult("cell5", cur);
    checkOutput("cell5_msg5",  64'(out_msg[5*MW +: MW]), 64'd3);
    checkOutput("cell5_map",   64'(out_err_map),         64'h0020);
    checkOutput("cell5_count", 64'(out_err_count),       64'd1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("hold_ready", {63'd0, in_ready},  64'd0);
      checkOutput("hold_msg",   64'(out_msg),       64'(cur.msg));
      checkOutput("hold_count", 64'(out_err_count), 64'(cur.cnt));
    end
    releaseResult("cell5");

    // Two independent negative errors at opposite corners.
    grid = fillGrid(0);
    grid[0*CW +: CW]  = 6'd37;
    grid[15*CW +: CW] = 6'd23;
    applyStimulus(grid, 1'b1);
    awaitResult("corners", cur);
    checkOutput("corners_msg0",  64'(out_msg[0*MW +: MW]),  64'd3);
    checkOutput("corners_msg15", 64'(out_msg[15*MW +: MW]), 64'd3);
    checkOutput("corners_count", 64'(out_err_count),        64'd2);
    releaseResult("corners");

    // Correction would leave the codeword range: cell 3 = 63.
    grid = fillGrid(0);
    grid[3*CW +: CW] = 6'd63;
    applyStimulus(grid, 1'b1);
    awaitResult("range", cur);
    checkOutput("range_msg3",   64'(out_msg[3*MW +: MW]), 64'd4);
    checkOutput("range_uncorr", {63'd0, out_uncorr},      64'd1);
    checkOutput("range_count",  64'(out_err_count),       64'd0);
    releaseResult("range");

    // Reset mid-scan discards the block.
    grid = fillGrid(26);
    grid[6*CW +: CW] = 6'd27;
    applyStimulus(grid, 1'b0);
    repeat (6) begin
      @(posedge clk); #1;
    end
    checkOutput("scan_busy", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready",  {63'd0, in_ready},   64'd1);
    checkOutput("midrst_out_valid", {63'd0, out_valid},  64'd0);
    checkOutput("midrst_msg",       64'(out_msg),        64'd0);
    checkOutput("midrst_map",       64'(out_err_map),    64'd0);
    checkOutput("midrst_count",     64'(out_err_count),  64'd0);
    checkOutput("midrst_uncorr",    {63'd0, out_uncorr}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    grid = fillGrid(52);
    grid[10*CW +: CW] = 6'd36;
    applyStimulus(grid, 1'b1);
    awaitResult("postrst", cur);
    releaseResult("postrst");

    // Randomised grids with sparse single-bit errors.
    for (int b = 0; b < 5; b++) begin
      applyStimulus(randomGrid(), 1'b1);
      awaitResult("random", cur);
      releaseResult("random");
    end

    checkOutput("queue_drained", 64'(sbQueue.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/an_grid_corrector.md
AN_GRID_CORRECTOR -- requirements
Module: an_grid_corrector

Interface
REQ-001 The module SHALL have parameter A, default 13, meaning the AN-code multiplier.
REQ-002 The module SHALL have parameter CW, default 6, meaning the codeword width in bits.
REQ-003 The module SHALL have parameter MW, default 3, meaning the message width in bits.
REQ-004 The module SHALL have parameter RW, default 4, meaning the residue width in bits.
REQ-005 The module SHALL have parameter ROWS, default 4, meaning the number of grid rows.
REQ-006 The module SHALL have parameter COLS, default 4, meaning the number of grid columns; N = ROWS*COLS, cell index i = row*COLS + col.
REQ-007 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The module SHALL have port in_valid, input, 1 bit: an input block is present.
REQ-010 The module SHALL have port in_ready, output, 1 bit: the block can accept a grid.
REQ-011 The module SHALL have port in_cw, input, N*CW bits: codewords, cell i at bits [i*CW +: CW].
REQ-012 The module SHALL have port out_valid, output, 1 bit: a result block is present.
REQ-013 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 The module SHALL have port out_msg, output, N*MW bits: decoded messages, same packing as in_cw.
REQ-015 The module SHALL have port out_err_map, output, N bits: bit i set when cell i had a nonzero residue.
REQ-016 The module SHALL have port out_err_count, output, clog2(N+1) bits: the number of corrected cells.
REQ-017 The module SHALL have port out_uncorr, output, 1 bit: at least one flagged cell was uncorrectable.

Function
REQ-018 The per-cell decode SHALL compute q = floor(cw/A) by Barrett reduction: M = floor(2^(2*CW)/A), q_est = (cw*M) >> (2*CW), r = cw - q_est*A, with a single conditional step (r >= A: r -= A, q += 1); q and r SHALL equal the exact quotient and remainder for every cw in 0..2^CW-1.
REQ-019 The cell error SHALL be defined as r != 0; row flag Er[j] SHALL be the OR over row j and column flag Ec[k] SHALL be the OR over column k.
REQ-020 A cell SHALL be a correction candidate iff Er[row] & Ec[col] & its own error bit are all set.
REQ-021 Correction SHALL find the unique e in {+2^k, -2^k : 0 <= k < CW} with e mod A == r, and SHALL set corrected = (cw - e)/A; if no e matches, or cw - e lies outside 0..2^CW-1, the cell SHALL be uncorrectable, SHALL output q unchanged, and SHALL set out_uncorr.
REQ-022 Non-candidate cells SHALL output q; each message SHALL be truncated to MW bits.
REQ-023 The FSM SHALL have the states IDLE, DETECT, SCAN and DONE.
REQ-024 IDLE SHALL assert in_ready=1; on in_valid, the block SHALL register in_cw and go to DETECT.
REQ-025 DETECT SHALL, in one cycle, register q, r, error, Er and Ec for all cells, clear the counters, and go to SCAN.
REQ-026 SCAN SHALL visit cell index 0..N-1, one per cycle, through a single shared corrector; it SHALL write candidate results and increment out_err_count per successful correction; after index N-1 it SHALL go to DONE.
REQ-027 DONE SHALL hold out_valid=1 and all outputs stable until out_ready=1, then go to IDLE on the next edge; in_ready SHALL be 0 outside IDLE, with no same-cycle bypass.
REQ-028 Latency SHALL be fixed at N+2 cycles from the accept edge to the out_valid rising edge, independent of the error count.
REQ-029 Multiple errors in the same block SHALL each be corrected independently.
REQ-030 An all-clean block SHALL produce out_err_map=0, out_err_count=0 and out_uncorr=0.

Reset
REQ-031 When rst_n=0, the block SHALL asynchronously enter IDLE with in_ready=1, out_valid=0, out_msg=0, out_err_map=0, out_err_count=0 and out_uncorr=0.
REQ-032 A reset during DETECT, SCAN or DONE SHALL discard the block in progress; no partial result SHALL appear.

Structure
REQ-033 The package an_grid_pkg SHALL hold the derived constants M, K=2*CW, N, the count width, and the state enum.
REQ-034 The per-cell Barrett decode SHALL be one sub-module, an_barrett_cell #(A,CW,MW,RW), instantiated N times; the shared corrector SHALL be inline logic.

Verification
REQ-035 Clean grid, all cells 39 -> all messages 3, out_err_map 0, out_valid at cycle N+2=18.
REQ-036 Cell 5 set to 43, others 39 -> r=4, e=+4, out_msg[5]=3, out_err_map=0x0020, out_err_count=1.
REQ-037 Cell 0 set to 37 (r=11, e=-2) and cell 15 set to 23 (r=10, e=-16), others 0 -> out_msg[0]=3, out_msg[15]=3, out_err_count=2.
REQ-038 Cell 3 set to 63 (r=11, e=-2, corrected cw 65 out of range) -> out_msg[3]=4, out_uncorr=1, out_err_count=0.
REQ-039 out_ready held low for 10 cycles in DONE -> outputs stable, in_ready=0; out_ready high -> IDLE on the next edge.
REQ-040 rst_n pulsed low mid-SCAN -> immediate IDLE, all outputs 0; the next block decodes correctly.
